// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its host/compute engine.
// master = sequencer side, slave = host/engine side.
interface layer_sequencer_if #(
    parameter int LAYER_W = 2
);
    logic               start;
    logic               abort;
    logic               done_init;
    logic               done_full;
    logic               linear_start;
    logic               compute_start;
    logic               compute_enable;
    logic               done_mem_modifier;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;
    logic               error;

    modport master (
        input  start, abort, done_init, done_full,
        output linear_start, compute_start, compute_enable, done_mem_modifier,
        output layer_idx, busy, done, error
    );

    modport slave (
        output start, abort, done_init, done_full,
        input  linear_start, compute_start, compute_enable, done_mem_modifier,
        input  layer_idx, busy, done, error
    );
endinterface

// File: rtl/layer_sequencer.sv
// Steps NUM_LAYERS layers through init / compute-kick / compute / mem-swap.
// Optional per-wait-state watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start, all strobes low
// S_INIT    | linear_start high, waiting for done_init
// S_CSTART  | one-cycle compute kick
// S_COMPUTE | compute_enable high, waiting for done_full
// S_MEMMOD  | one-cycle memory swap, then next layer or finish
// S_FINISH  | one-cycle done pulse
// S_ERR     | watchdog expired, error held until abort
module layer_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int LAYER_W        = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    layer_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_CSTART  = 3'd2,
        S_COMPUTE = 3'd3,
        S_MEMMOD  = 3'd4,
        S_FINISH  = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_IDX = LAYER_W'(NUM_LAYERS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [LAYER_W-1:0] layer_q;
    logic [LAYER_W-1:0] layer_d;
    logic               wd_hit;

    generate
        if (NUM_LAYERS < 1 || NUM_LAYERS > (1 << LAYER_W)) begin : g_bad_layers
            $error("layer_sequencer: NUM_LAYERS out of range for LAYER_W");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("layer_sequencer: TIMEOUT_CYCLES out of range");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        // abort outranks every done input and the watchdog
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            layer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_INIT;
                        layer_d = '0;
                    end
                end
                S_INIT: begin
                    if (bus.done_init) begin
                        state_d = S_CSTART;
                    end else if (wd_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_CSTART: state_d = S_COMPUTE;
                S_COMPUTE: begin
                    if (bus.done_full) begin
                        state_d = S_MEMMOD;
                    end else if (wd_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_MEMMOD: begin
                    if (layer_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_INIT;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end
                S_FINISH: state_d = S_IDLE;
                S_ERR:    state_d = S_ERR;
                default:  state_d = S_IDLE;
            endcase
        end
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;

    // Every entry into a wait state comes from a non-wait state, so clearing
    // outside the wait states restarts the count on each entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state_q == S_INIT || state_q == S_COMPUTE) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_hit    = (wd_cnt == WD_LAST);
    assign bus.error = (state_q == S_ERR);
`else
    assign wd_hit    = 1'b0;
    assign bus.error = 1'b0;
`endif

    assign bus.linear_start      = (state_q == S_INIT);
    assign bus.compute_start     = (state_q == S_CSTART);
    assign bus.compute_enable    = (state_q == S_CSTART) || (state_q == S_COMPUTE);
    assign bus.done_mem_modifier = (state_q == S_MEMMOD);
    assign bus.done              = (state_q == S_FINISH);
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.layer_idx         = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NUM_LAYERS=3, TIMEOUT_CYCLES=8.
// Watchdog scenarios run only when LAYER_SEQ_TIMEOUT_EN is defined.
module tb_layer_sequencer;

    localparam int NL = 3;
    localparam int LW = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    layer_sequencer_if #(.LAYER_W(LW)) sq_if ();

    layer_sequencer #(
        .NUM_LAYERS     (NL),
        .LAYER_W        (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sq_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        for (int c = 1; c <= budget && n == 0; c++) begin
            tick();
            if (sq_if.done) n = c;
        end
    endtask

    // Reach COMPUTE of layer 1 with done_init held high; layer 0 compute is answered.
    task automatic run_to_compute_l1(output bit reached);
        reached = 1'b0;
        sq_if.done_init = 1'b1;
        sq_if.done_full = 1'b0;
        sq_if.start     = 1'b1;
        for (int c = 1; c <= 30 && !reached; c++) begin
            tick();
            sq_if.start = 1'b0;
            if (sq_if.compute_enable && !sq_if.compute_start && sq_if.layer_idx == 2'd1)
                reached = 1'b1;
            else
                sq_if.done_full = (sq_if.layer_idx == 2'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int         n;
        int         done_at;
        int         ls_pulses;
        int         mm_cnt;
        int         cs_cnt;
        int         done_cnt;
        int         iw;
        int         cw;
        bit         prev_ls;
        bit         reached;
        logic [5:0] mm_layers;

        sq_if.start     = 1'b0;
        sq_if.abort     = 1'b0;
        sq_if.done_init = 1'b0;
        sq_if.done_full = 1'b0;
        rst = 1'b0;
        #2;
        check("rst_busy",    32'(sq_if.busy), 0);
        check("rst_layer",   32'(sq_if.layer_idx), 0);
        check("rst_strobes", 32'({sq_if.linear_start, sq_if.compute_start, sq_if.compute_enable,
                                  sq_if.done_mem_modifier, sq_if.done, sq_if.error}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("idle_busy", 32'(sq_if.busy), 0);

        // Done inputs tied high: 13 cycles from start to done
        sq_if.done_init = 1'b1;
        sq_if.done_full = 1'b1;
        sq_if.start     = 1'b1;
        done_at = 0; mm_cnt = 0; cs_cnt = 0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            tick();
            if (c == 1) begin
                sq_if.start = 1'b0;
                check("fast_first_layer", 32'(sq_if.layer_idx), 0);
                check("fast_first_init",  32'(sq_if.linear_start), 1);
            end
            if (sq_if.done_mem_modifier) mm_cnt++;
            if (sq_if.compute_start) cs_cnt++;
            if (sq_if.done) begin
                done_at = c;
                check("fast_layer_at_done", 32'(sq_if.layer_idx), 2);
            end
        end
        check("fast_done_latency", done_at, 13);
        check("fast_memmod_count", mm_cnt, 3);
        check("fast_cstart_count", cs_cnt, 3);
        sq_if.done_init = 1'b0;
        sq_if.done_full = 1'b0;
        tick();
        check("fast_done_one_cycle", 32'(sq_if.done), 0);
        check("fast_idle_after",     32'(sq_if.busy), 0);
        check("fast_layer_hold",     32'(sq_if.layer_idx), 2);

        // Responder answers each request two cycles after it appears
        sq_if.start = 1'b1;
        done_at = 0; ls_pulses = 0; mm_cnt = 0; cs_cnt = 0; done_cnt = 0;
        iw = 0; cw = 0; prev_ls = 1'b0; mm_layers = '0;
        for (int c = 1; c <= 100 && done_at == 0; c++) begin
            tick();
            sq_if.start = 1'b0;
            if (sq_if.linear_start && !prev_ls) ls_pulses++;
            prev_ls = sq_if.linear_start;
            if (sq_if.compute_start) cs_cnt++;
            if (sq_if.done_mem_modifier) begin
                mm_layers = {mm_layers[3:0], sq_if.layer_idx};
                mm_cnt++;
            end
            if (sq_if.done) begin
                done_at = c;
                done_cnt++;
            end
            if (sq_if.linear_start) begin
                sq_if.done_init = (iw == 2);
                iw++;
            end else begin
                sq_if.done_init = 1'b0;
                iw = 0;
            end
            if (sq_if.compute_enable && !sq_if.compute_start) begin
                sq_if.done_full = (cw == 2);
                cw++;
            end else begin
                sq_if.done_full = 1'b0;
                cw = 0;
            end
        end
        check("slow_linear_pulses", ls_pulses, 3);
        check("slow_memmod_count",  mm_cnt, 3);
        check("slow_layer_seq",     32'(mm_layers), 6);
        check("slow_cstart_count",  cs_cnt, 3);
        check("slow_done_latency",  done_at, 25);
        tick();
        check("slow_done_once", 32'(sq_if.done), 0);

        // Abort in COMPUTE of layer 1 together with done_full
        run_to_compute_l1(reached);
        check("abort_reached_l1", 32'(reached), 1);
        sq_if.abort     = 1'b1;
        sq_if.done_full = 1'b1;
        tick();
        check("abort_busy",    32'(sq_if.busy), 0);
        check("abort_layer",   32'(sq_if.layer_idx), 0);
        check("abort_no_mm",   32'(sq_if.done_mem_modifier), 0);
        check("abort_cen",     32'(sq_if.compute_enable), 0);
        sq_if.abort     = 1'b0;
        sq_if.done_full = 1'b0;
        sq_if.done_init = 1'b0;
        tick();
        check("abort_no_mm_after", 32'(sq_if.done_mem_modifier), 0);
        check("abort_stays_idle",  32'(sq_if.busy), 0);

        // Async reset between edges during COMPUTE of layer 1
        run_to_compute_l1(reached);
        check("rst_reached_l1", 32'(reached), 1);
        #3 rst = 1'b0;
        #1;
        check("arst_busy",  32'(sq_if.busy), 0);
        check("arst_cen",   32'(sq_if.compute_enable), 0);
        check("arst_layer", 32'(sq_if.layer_idx), 0);
        sq_if.done_init = 1'b1;
        sq_if.done_full = 1'b1;
        tick();
        check("arst_no_mm",   32'(sq_if.done_mem_modifier), 0);
        check("arst_no_done", 32'(sq_if.done), 0);
        rst = 1'b1;
        tick();
        check("arst_release_idle", 32'(sq_if.busy), 0);
        sq_if.start = 1'b1;
        tick();
        sq_if.start = 1'b0;
        check("arst_rerun_layer", 32'(sq_if.layer_idx), 0);
        check("arst_rerun_init",  32'(sq_if.linear_start), 1);
        wait_done(40, n);
        check("arst_rerun_latency", n, 12);
        sq_if.done_init = 1'b0;
        sq_if.done_full = 1'b0;
        tick();

        // Spurious inputs: done_init/done_full in IDLE, done_full and start in INIT
        sq_if.done_init = 1'b1;
        sq_if.done_full = 1'b1;
        sq_if.abort     = 1'b1;
        tick();
        check("idle_ignore_dones", 32'(sq_if.busy), 0);
        sq_if.done_init = 1'b0;
        sq_if.done_full = 1'b0;
        sq_if.abort     = 1'b0;
        sq_if.start     = 1'b1;
        tick();
        sq_if.start = 1'b0;
        check("spur_in_init", 32'(sq_if.linear_start), 1);
        sq_if.done_full = 1'b1;
        sq_if.start     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("spur_outs", 32'({sq_if.busy, sq_if.linear_start, sq_if.compute_enable,
                                    sq_if.done_mem_modifier, sq_if.done, sq_if.layer_idx}),
                  32'b1_1_0_0_0_00);
        end
        sq_if.done_full = 1'b0;
        sq_if.start     = 1'b0;
        sq_if.abort     = 1'b1;
        tick();
        sq_if.abort = 1'b0;
        check("spur_abort_idle", 32'(sq_if.busy), 0);

`ifdef LAYER_SEQ_TIMEOUT_EN
        // Watchdog expiry in INIT
        sq_if.start = 1'b1;
        done_at = 0; ls_pulses = 0;
        for (int c = 1; c <= 30 && done_at == 0; c++) begin
            tick();
            sq_if.start = 1'b0;
            if (sq_if.linear_start) ls_pulses++;
            if (sq_if.error) done_at = c;
        end
        check("wd_error_cycle", done_at, 9);
        check("wd_init_cycles", ls_pulses, 8);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wd_err_hold", 32'({sq_if.error, sq_if.busy, sq_if.linear_start,
                                      sq_if.compute_enable, sq_if.done}), 32'b11000);
        end
        sq_if.abort = 1'b1;
        tick();
        sq_if.abort = 1'b0;
        check("wd_abort_error", 32'(sq_if.error), 0);
        check("wd_abort_busy",  32'(sq_if.busy), 0);

        // done_full on the last allowed COMPUTE cycle beats the watchdog
        sq_if.done_init = 1'b1;
        sq_if.start     = 1'b1;
        tick();
        sq_if.start = 1'b0;
        tick();
        tick();
        check("wd_in_compute", 32'(sq_if.compute_enable && !sq_if.compute_start), 1);
        repeat (7) tick();
        sq_if.done_full = 1'b1;
        tick();
        check("wd_done_wins_mm",  32'(sq_if.done_mem_modifier), 1);
        check("wd_done_wins_err", 32'(sq_if.error), 0);
        sq_if.done_full = 1'b0;
        sq_if.done_init = 1'b0;
        sq_if.abort     = 1'b1;
        tick();
        sq_if.abort = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
